alu_md: RTL

- Parametrised successor to the execute-stage ALU.
- Keeps the same single-cycle op set, now with a registered result.
- Adds ADD/SUB overflow and carry flags.
- Adds an iterative multiply/divide engine with architectural HI/LO registers, MFHI/MFLO reads, and a start/done handshake.
- Sits in EX. Hazard logic stalls the pipeline while busy=1.

---
 rtl/alu_md_if.sv | 28 ++
 rtl/alu_md.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_if.sv
// Request/response bundle between the EX-stage control and the alu_md unit.
// master drives the request side; slave is the ALU itself.
interface alu_md_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             start;
  logic             flush;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, flush, op, a, b,
    input  busy, done, result, flags, hi, lo
  );

  modport slave (
    input  start, flush, op, a, b,
    output busy, done, result, flags, hi, lo
  );
endinterface

// File: rtl/alu_md.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative
// shift-add multiplier / restoring divider writing architectural HI/LO.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input logic     clk,
  input logic     rst_n,
  alu_md_if.slave bus
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH) + 1;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(2);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(3);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(4);
  localparam logic [OPW-1:0] OP_AND   = OPW'(5);
  localparam logic [OPW-1:0] OP_OR    = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(7);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(8);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(9);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(10);
  localparam logic [OPW-1:0] OP_MULT  = OPW'(11);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(12);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(13);
  localparam logic [OPW-1:0] OP_MFHI  = OPW'(14);
  localparam logic [OPW-1:0] OP_MFLO  = OPW'(15);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_wide_if(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  state_t           state;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNTW-1:0]  cnt;

  logic             vld_p0;
  logic [OPW-1:0]   op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mag_op;
  logic [WIDTH-1:0] a_raw;
  logic             sign_a;
  logic             sign_b;
  logic             md_div;

  logic accept;
  logic is_md_op;
  logic is_div_op;
  logic signed_op;

  assign accept    = bus.start && !busy && !bus.flush;
  assign is_md_op  = (bus.op == OP_MULTU) || (bus.op == OP_MULT) ||
                     (bus.op == OP_DIVU)  || (bus.op == OP_DIV);
  assign is_div_op = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);

  // ---- stage p0 -> p1: single-cycle evaluation on latched operands ----
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [SHW-1:0]          shamt;
  logic [WIDTH:0]          sum_c;
  logic [WIDTH-1:0]        dif_c;
  logic [WIDTH-1:0]        res_c;
  logic                    v_c;
  logic                    c_c;

  assign a_s   = a_p0;
  assign b_s   = b_p0;
  assign shamt = b_p0[SHW-1:0];

  always_comb begin
    res_c = '0;
    v_c   = 1'b0;
    c_c   = 1'b0;
    sum_c = {1'b0, a_p0} + {1'b0, b_p0};
    dif_c = a_p0 - b_p0;
    case (op_p0)
      OP_ADD: begin
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = (a_p0[WIDTH-1] == b_p0[WIDTH-1]) && (sum_c[WIDTH-1] != a_p0[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = dif_c;
        c_c   = a_p0 < b_p0;
        v_c   = (a_p0[WIDTH-1] != b_p0[WIDTH-1]) && (dif_c[WIDTH-1] != a_p0[WIDTH-1]);
      end
      OP_SLL:  res_c = a_p0 << shamt;
      OP_SRL:  res_c = a_p0 >> shamt;
      OP_SRA:  res_c = a_s >>> shamt;
      OP_AND:  res_c = a_p0 & b_p0;
      OP_OR:   res_c = a_p0 | b_p0;
      OP_XOR:  res_c = a_p0 ^ b_p0;
      OP_SLTU: res_c = WIDTH'(a_p0 < b_p0);
      OP_SLT:  res_c = WIDTH'(a_s < b_s);
      OP_MFHI: res_c = hi;
      OP_MFLO: res_c = lo;
      default: res_c = '0;
    endcase
  end

  // ---- iteration step of the mul/div engine ----
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_try;
  logic           div_geq;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_op} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_try   = div_shift - {1'b0, mag_op};
    div_geq   = div_shift >= {1'b0, mag_op};
  end

  // ---- FIX stage: sign correction and divide-by-zero override ----
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   md_hi;
  logic [WIDTH-1:0]   md_lo;

  always_comb begin
    prod_fix = neg_wide_if({acc_hi, acc_lo}, sign_a ^ sign_b);
    if (!md_div) begin
      md_hi = prod_fix[2*WIDTH-1:WIDTH];
      md_lo = prod_fix[WIDTH-1:0];
    end else if (mag_op == '0) begin
      md_hi = a_raw;
      md_lo = '1;
    end else begin
      md_hi = neg_if(acc_hi, sign_a);
      md_lo = neg_if(acc_lo, sign_a ^ sign_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      vld_p0 <= 1'b0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done   <= 1'b0;
      vld_p0 <= accept && !is_md_op;
      if (vld_p0 && !bus.flush) begin
        result <= res_c;
        flags  <= {res_c[WIDTH-1], res_c == '0, v_c, c_c};
        done   <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept && is_md_op) begin
            state <= is_div_op ? DIV : MUL;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNTW'(1);
            if (cnt == CNTW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!bus.flush) begin
            hi     <= md_hi;
            lo     <= md_lo;
            result <= md_lo;
            flags  <= {md_lo[WIDTH-1], md_lo == '0, 2'b00};
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and engine registers carry data only; control above gates their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= bus.op;
      a_p0  <= bus.a;
      b_p0  <= bus.b;
    end
    if (accept && is_md_op) begin
      a_raw  <= bus.a;
      sign_a <= signed_op & bus.a[WIDTH-1];
      sign_b <= signed_op & bus.b[WIDTH-1];
      md_div <= is_div_op;
      acc_hi <= '0;
      if (is_div_op) begin
        mag_op <= neg_if(bus.b, signed_op & bus.b[WIDTH-1]);
        acc_lo <= neg_if(bus.a, signed_op & bus.a[WIDTH-1]);
      end else begin
        mag_op <= neg_if(bus.a, signed_op & bus.a[WIDTH-1]);
        acc_lo <= neg_if(bus.b, signed_op & bus.b[WIDTH-1]);
      end
    end else if (state == MUL) begin
      {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
    end else if (state == DIV) begin
      acc_hi <= div_geq ? div_try[WIDTH-1:0] : div_shift[WIDTH-1:0];
      acc_lo <= {acc_lo[WIDTH-2:0], div_geq};
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;
  assign bus.flags  = flags;
  assign bus.hi     = hi;
  assign bus.lo     = lo;
endmodule
